tilelink_to_uart_bridge: RTL
============================

# tilelink_to_uart_bridge

Return-path bridge from the TileLink deserializer to the host UART. It captures one TileLink frame (normally a Channel D response) from the GenericDeserializer output. It packs the frame into the same 16-byte little-endian packet the host tool decodes with `struct.unpack("<BBBBLQ")`, then streams the packet one byte at a time to the STL UART transmit client.

## Interface
Parameters: none.

Ports:
- sysclk  in  1  system clock; all state is clocked on its rising edge
- reset  in  1  synchronous, active-high
- tl_clk  in  1  serializer clock, sampled as data in the sysclk domain
- tl_out_valid  in  1  deserializer frame valid
- tl_out_ready  out  1  bridge can accept a frame
- tl_out_bits_chanId  in  3  channel ID
- tl_out_bits_opcode  in  3  opcode
- tl_out_bits_param  in  3  param
- tl_out_bits_size  in  8  log2 transfer size
- tl_out_bits_source  in  8  source; ignored
- tl_out_bits_address  in  64  address; only [31:0] transmitted
- tl_out_bits_data  in  64  data
- tl_out_bits_corrupt  in  1  corrupt
- tl_out_bits_union  in  9  union (denied for Ch D); only [7:0] transmitted
- tl_out_bits_last  in  1  last beat; ignored
- tx_byte_valid  out  1  byte available to UART TX
- tx_byte_ready  in  1  UART TX accepts the byte
- tx_byte_data  out  8  byte to transmit
- trunc_err  out  1  sticky flag: a captured frame had address[63:32]≠0 or union[8]=1

## Operation
- Edge detect: register `tl_clk_q` <= tl_clk every sysclk cycle. `tl_edge` = tl_clk & ~tl_clk_q. `tl_clk_q` resets to 1 so that no false edge occurs when reset is released.
- State machine (2 states):
  - IDLE: tl_out_ready=1, tx_byte_valid=0. When `tl_edge & tl_out_valid`, capture the frame into the 128-bit `pkt`, clear byte_idx to 0, and go to SEND.
  - SEND: tl_out_ready=0, tx_byte_valid=1, tx_byte_data=pkt[8*byte_idx+7 : 8*byte_idx].
    - On tx_byte_ready with byte_idx<15: increment byte_idx.
    - On tx_byte_ready with byte_idx=15: go to IDLE.
- Packing, byte 0 first:
  - B0 = {5'b0, chanId}
  - B1 = {corrupt, param, 1'b0, opcode}
  - B2 = size
  - B3 = union[7:0]
  - B4–B7 = address[31:0], LSB first
  - B8–B15 = data[63:0], LSB first
- trunc_err sets on any capture with address[63:32]≠0 or union[8]=1. It clears only on reset.
- tx_byte_data is stable while tx_byte_valid=1 and tx_byte_ready=0.
- Frames are never dropped silently. While in SEND the deserializer is back-pressured by tl_out_ready=0.

## Timing
- Reset values:
  - tl_out_ready=0 while reset is asserted; 1 in the first cycle after reset.
  - tx_byte_valid=0, tx_byte_data=8'h00, trunc_err=0.
  - State IDLE, byte_idx=0, pkt=0.
- Capture latency: tx_byte_valid rises the cycle after the capturing `tl_edge` cycle. tl_out_ready falls in that same cycle.
- Throughput with tx_byte_ready held at 1:
  - 16 consecutive bytes in 16 cycles.
  - IDLE is re-entered in the cycle after byte 15 is accepted.
  - Minimum 17 sysclk cycles per frame, plus wait for the next tl_edge.
- tl_out_valid without a coincident tl_edge, or while in SEND, is ignored.
- Reset asserted mid-packet aborts the packet. No partial resume; byte_idx returns to 0.
- Requirements on tl_clk: it is derived from sysclk, at most sysclk/4, and tl_out_* is stable across each tl_clk rising edge.

## Configuration
- `TL2UART_CHAN_FILTER_EN` defined:
  - A frame with chanId≠3 is handshaken (consumed) but not transmitted.
  - The state stays IDLE, tx_byte_valid stays 0, and trunc_err is not updated.
- Not defined: every channel ID is transmitted.

## Structure
- Shared package `tl_uart_pkg` holds:
  - Packet length constant (16).
  - Byte offsets: CHAN=0, OPC=1, SIZE=2, UNION=3, ADDR=4, DATA=8.
  - Channel ID constants CH_A=0, CH_D=3.
  - Bit positions of the packed opcode byte.
- Natural sub-module: `tl_packet_packer`, purely combinational frame→128-bit packing. The same layout is mirrored by the RX bridge's unpacker.

## Test plan
- Ch D AccessAckData frame (chanId=3, opcode=1, param=0, size=3, union=0, addr=0x0000_0000_8000_1000, data=0x1122334455667788), tx_byte_ready=1 -> bytes 03 01 03 00 00 10 00 80 88 77 66 55 44 33 22 11 on 16 consecutive cycles; trunc_err=0.
- Same frame with tx_byte_ready toggling 1/0 -> identical byte sequence; tx_byte_data held on every stall cycle; tl_out_ready=0 until byte 15 is accepted.
- corrupt=1, param=5, opcode=6, union=9'h101, addr[63:32]=1 -> B1=0xD6, B3=0x01, trunc_err=1 and still 1 after the next clean frame.
- Two back-to-back frames with tl_out_valid held -> second frame captured only on the first tl_edge after return to IDLE; no byte interleaving.
- Reset after byte 6 -> tx_byte_valid=0 the cycle after reset; next frame starts at byte 0. tl_clk high at reset release -> no spurious capture.
- With `TL2UART_CHAN_FILTER_EN`, a chanId=0 frame -> consumed, zero bytes emitted. Without the macro -> 16 bytes with B0=0x00.

Source files
------------

// File: rtl/tl_uart_pkg.sv
// Shared packet layout for the TileLink <-> UART bridges: 16-byte little-endian
// frame image matching the host's struct.unpack("<BBBBLQ").
package tl_uart_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   localparam int PKT_LEN  = 16;
   localparam int PKT_BITS = 8 * PKT_LEN;
   localparam logic [3:0] LAST_BYTE_IDX = 4'(PKT_LEN - 1);

   localparam int OFF_CHAN  = 0;
   localparam int OFF_OPC   = 1;
   localparam int OFF_SIZE  = 2;
   localparam int OFF_UNION = 3;
   localparam int OFF_ADDR  = 4;
   localparam int OFF_DATA  = 8;

   localparam logic [2:0] CH_A = 3'd0;
   localparam logic [2:0] CH_D = 3'd3;

   // Opcode byte: {corrupt, param[2:0], 1'b0, opcode[2:0]}
   localparam int OPC_OPCODE_LSB  = 0;
   localparam int OPC_PARAM_LSB   = 4;
   localparam int OPC_CORRUPT_BIT = 7;

   function automatic logic [7:0] pack_opc_byte(input logic       corrupt,
                                                input logic [2:0] param,
                                                input logic [2:0] opcode);
      logic [7:0] b;
      b                          = '0;
      b[OPC_OPCODE_LSB +: 3]     = opcode;
      b[OPC_PARAM_LSB +: 3]      = param;
      b[OPC_CORRUPT_BIT]         = corrupt;
      return b;
   endfunction

endpackage

// File: rtl/tl_packet_packer.sv
// Combinational TileLink frame -> 128-bit packet image; byte 0 sits in bits [7:0].
// The RX bridge's unpacker mirrors this layout.
module tl_packet_packer
   import tl_uart_pkg::*;
(
   input  logic [2:0]          chan_id,
   input  logic [2:0]          opcode,
   input  logic [2:0]          param,
   input  logic [7:0]          size,
   input  logic [7:0]          union_lo,
   input  logic [31:0]         address,
   input  logic [63:0]         data,
   input  logic                corrupt,
   output logic [PKT_BITS-1:0] pkt
);

   always_comb begin
      pkt                      = '0;
      pkt[8*OFF_CHAN  +: 8]    = {5'b0, chan_id};
      pkt[8*OFF_OPC   +: 8]    = pack_opc_byte(corrupt, param, opcode);
      pkt[8*OFF_SIZE  +: 8]    = size;
      pkt[8*OFF_UNION +: 8]    = union_lo;
      pkt[8*OFF_ADDR  +: 32]   = address;
      pkt[8*OFF_DATA  +: 64]   = data;
   end

endmodule

// File: rtl/tilelink_to_uart_bridge.sv
// Captures one TileLink frame on a tl_clk rising edge and streams it as 16 bytes
// to the UART TX client. Optional build macro: TL2UART_CHAN_FILTER_EN (drop non-Ch-D frames).
module tilelink_to_uart_bridge
   import tl_uart_pkg::*;
(
   input  logic        sysclk,
   input  logic        reset,
   input  logic        tl_clk,
   input  logic        tl_out_valid,
   output logic        tl_out_ready,
   input  logic [2:0]  tl_out_bits_chanId,
   input  logic [2:0]  tl_out_bits_opcode,
   input  logic [2:0]  tl_out_bits_param,
   input  logic [7:0]  tl_out_bits_size,
   input  logic [7:0]  tl_out_bits_source,
   input  logic [63:0] tl_out_bits_address,
   input  logic [63:0] tl_out_bits_data,
   input  logic        tl_out_bits_corrupt,
   input  logic [8:0]  tl_out_bits_union,
   input  logic        tl_out_bits_last,
   output logic        tx_byte_valid,
   input  logic        tx_byte_ready,
   output logic [7:0]  tx_byte_data,
   output logic        trunc_err
);

   // Handshakes: a frame transfers when tl_out_valid & tl_out_ready coincide
   // with tl_edge; a byte transfers on a sysclk edge with tx_byte_valid & tx_byte_ready.

   state_e              state;
   state_e              state_next;
   logic                tl_clk_q;
   logic                tl_edge;
   logic [PKT_BITS-1:0] pkt;
   logic [PKT_BITS-1:0] pkt_next;
   logic [3:0]          byte_idx;
   logic [6:0]          bit_base;
   logic                capture;
   logic                advance;
   logic                frame_ok;
   logic                trunc_hit;
   logic                unused_inputs;

   assign unused_inputs = ^{tl_out_bits_source, tl_out_bits_last};

   tl_packet_packer u_packer (
      .chan_id  (tl_out_bits_chanId),
      .opcode   (tl_out_bits_opcode),
      .param    (tl_out_bits_param),
      .size     (tl_out_bits_size),
      .union_lo (tl_out_bits_union[7:0]),
      .address  (tl_out_bits_address[31:0]),
      .data     (tl_out_bits_data),
      .corrupt  (tl_out_bits_corrupt),
      .pkt      (pkt_next)
   );

   assign tl_edge   = tl_clk & ~tl_clk_q;
   assign trunc_hit = (|tl_out_bits_address[63:32]) | tl_out_bits_union[8];

`ifdef TL2UART_CHAN_FILTER_EN
   assign frame_ok = (tl_out_bits_chanId == CH_D);
`else
   assign frame_ok = 1'b1;
`endif

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Filtered frames are still handshaken in IDLE; they simply never leave it.
   always_comb begin
      state_next    = state;
      tl_out_ready  = 1'b0;
      tx_byte_valid = 1'b0;
      capture       = 1'b0;
      advance       = 1'b0;
      case (state)
         ST_IDLE: begin
            tl_out_ready = ~reset;
            if (tl_edge && tl_out_valid && frame_ok) begin
               capture    = 1'b1;
               state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            tx_byte_valid = ~reset;
            if (tx_byte_ready) begin
               advance = 1'b1;
               if (byte_idx == LAST_BYTE_IDX) begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         tl_clk_q  <= 1'b1;
         pkt       <= '0;
         byte_idx  <= '0;
         trunc_err <= 1'b0;
      end else begin
         tl_clk_q <= tl_clk;
         if (capture) begin
            pkt      <= pkt_next;
            byte_idx <= '0;
            if (trunc_hit) begin
               trunc_err <= 1'b1;
            end
         end else if (advance) begin
            byte_idx <= byte_idx + 4'd1;
         end
      end
   end

   assign bit_base     = {byte_idx, 3'b000};
   assign tx_byte_data = pkt[bit_base +: 8];

endmodule
